tank_irrigation_ctrl: RTL and testbench

Clocked, parametrised successor to the combinational tank/irrigation error logic.
- Accepts N_LEVELS tank level sensors plus the soil, air and temperature sensors, debounces every input, and validates the level pattern as thermometer code, with a latched error and a timed clear.
- Runs an irrigation state machine (sprinkler or drip, chosen at start, duty-limited with a forced rest).
- Controls the inlet valve with hysteresis and drives the alarm.
- Sits between the sensor pins and the LED/actuator outputs.

---
 rtl/tank_irrigation_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_tank_irrigation_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tank_irrigation_ctrl.sv
// Tank level validation, inlet valve hysteresis and duty-limited irrigation FSM.
// All sensor inputs are debounced; every output is registered.
module tank_irrigation_ctrl #(
    parameter int N_LEVELS    = 3,
    parameter int DEB_CYCLES  = 4,
    parameter int CLR_CYCLES  = 8,
    parameter int IRR_MAX     = 16,
    parameter int REST_CYCLES = 8,
    parameter int FILL_ON     = 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_LEVELS-1:0]               Nivel,
    input  logic                              Temp,
    input  logic                              Usolo,
    input  logic                              Uar,
    output logic [$clog2(N_LEVELS+1)-1:0]     Fill,
    output logic                              ErroMedida,
    output logic                              Aspersor,
    output logic                              Gotejamento,
    output logic                              VEntrada,
    output logic                              Alarme
);

    localparam int NB = N_LEVELS + 3;
    localparam int FW = $clog2(N_LEVELS + 1);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int RW = $clog2(IRR_MAX + 1);
    localparam int TW = $clog2(REST_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, IRRIGATE, REST} state_t;

    logic [NB-1:0]          raw;
    logic [NB-1:0]          deb_q, deb_d;
    logic [NB-1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;

    logic [N_LEVELS-1:0]    lvl, lvl_inc;
    logic                   temp_deb, usolo_deb, uar_deb;
    logic                   level_ok;
    logic [FW-1:0]          level_cnt;

    logic [FW-1:0]          fill_q, fill_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          clr_cnt_q, clr_cnt_d;
    logic                   vent_q, vent_d;
    logic                   alarm_q, alarm_d;

    state_t                 state_q, state_d;
    logic                   sprk_q, sprk_d;
    logic [RW-1:0]          run_q, run_d;
    logic [TW-1:0]          rest_q, rest_d;
    logic                   asp_q, asp_d;
    logic                   got_q, got_d;

    assign raw       = {Uar, Usolo, Temp, Nivel};
    assign lvl       = deb_q[N_LEVELS-1:0];
    assign temp_deb  = deb_q[N_LEVELS];
    assign usolo_deb = deb_q[N_LEVELS+1];
    assign uar_deb   = deb_q[N_LEVELS+2];

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (raw[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                deb_d[i]     = ~deb_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Thermometer code 2^k-1 has no bit in common with itself plus one.
    always_comb begin
        lvl_inc   = lvl + N_LEVELS'(1);
        level_ok  = (lvl & lvl_inc) == '0;
        level_cnt = '0;
        for (int unsigned i = 0; i < N_LEVELS; i++) begin
            level_cnt = level_cnt + FW'(lvl[i]);
        end

        fill_d    = level_ok ? level_cnt : fill_q;
        err_d     = err_q;
        clr_cnt_d = '0;
        if (!level_ok) begin
            err_d = 1'b1;
        end else if (err_q) begin
            if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                err_d = 1'b0;
            end else begin
                clr_cnt_d = clr_cnt_q + CW'(1);
            end
        end

        if (err_d || fill_d == FW'(N_LEVELS)) begin
            vent_d = 1'b0;
        end else if (fill_d <= FW'(FILL_ON)) begin
            vent_d = 1'b1;
        end else begin
            vent_d = vent_q;
        end
        alarm_d = err_d | (fill_d == '0);
    end

    // Next-state terms use err_d/fill_d so an abort lands on the same edge as the error.
    always_comb begin
        state_d = state_q;
        sprk_d  = sprk_q;
        run_d   = run_q;
        rest_d  = rest_q;
        case (state_q)
            IDLE: begin
                if (usolo_deb && !err_d && fill_d != '0) begin
                    state_d = IRRIGATE;
                    sprk_d  = uar_deb & ~temp_deb;
                    run_d   = '0;
                end
            end
            IRRIGATE: begin
                if (!usolo_deb || err_d || fill_d == '0 || run_q == RW'(IRR_MAX - 1)) begin
                    state_d = REST;
                    rest_d  = '0;
                end else begin
                    run_d = run_q + RW'(1);
                end
            end
            REST: begin
                if (rest_q == TW'(REST_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rest_d = rest_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        asp_d = (state_d == IRRIGATE) && sprk_d;
        got_d = (state_d == IRRIGATE) && !sprk_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q     <= '0;
            deb_cnt_q <= '0;
            fill_q    <= '0;
            err_q     <= 1'b0;
            clr_cnt_q <= '0;
            vent_q    <= 1'b0;
            alarm_q   <= 1'b0;
            state_q   <= IDLE;
            sprk_q    <= 1'b0;
            run_q     <= '0;
            rest_q    <= '0;
            asp_q     <= 1'b0;
            got_q     <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            fill_q    <= fill_d;
            err_q     <= err_d;
            clr_cnt_q <= clr_cnt_d;
            vent_q    <= vent_d;
            alarm_q   <= alarm_d;
            state_q   <= state_d;
            sprk_q    <= sprk_d;
            run_q     <= run_d;
            rest_q    <= rest_d;
            asp_q     <= asp_d;
            got_q     <= got_d;
        end
    end

    assign Fill        = fill_q;
    assign ErroMedida  = err_q;
    assign Aspersor    = asp_q;
    assign Gotejamento = got_q;
    assign VEntrada    = vent_q;
    assign Alarme      = alarm_q;

endmodule

// File: tb/tb_tank_irrigation_ctrl.sv
// Directed bench for tank_irrigation_ctrl with hand-computed expectations
// (N_LEVELS=3, DEB_CYCLES=4, CLR_CYCLES=8, IRR_MAX=16, REST_CYCLES=8, FILL_ON=1).
module tb_tank_irrigation_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] Nivel;
    logic       Temp, Usolo, Uar;
    logic [1:0] Fill;
    logic       ErroMedida, Aspersor, Gotejamento, VEntrada, Alarme;

    int checks = 0;
    int errors = 0;

    tank_irrigation_ctrl #(
        .N_LEVELS(3), .DEB_CYCLES(4), .CLR_CYCLES(8),
        .IRR_MAX(16), .REST_CYCLES(8), .FILL_ON(1)
    ) dut (
        .clk(clk), .reset(reset), .Nivel(Nivel), .Temp(Temp), .Usolo(Usolo), .Uar(Uar),
        .Fill(Fill), .ErroMedida(ErroMedida), .Aspersor(Aspersor),
        .Gotejamento(Gotejamento), .VEntrada(VEntrada), .Alarme(Alarme)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Nivel = 3'b000; Temp = 0; Usolo = 0; Uar = 0;
        tick(2);
        checks++; if (Fill !== 2'd0) begin errors++; $display("FAIL rst_fill: got %0d expected 0", Fill); end
        checks++; if ({ErroMedida, Aspersor, Gotejamento, VEntrada, Alarme} !== 5'b0) begin
            errors++; $display("FAIL rst_outputs: got %b expected 00000", {ErroMedida, Aspersor, Gotejamento, VEntrada, Alarme}); end
        reset = 1'b0;
    endtask

    task automatic test_debounce();
        tick(1);
        Nivel = 3'b001; tick(3);
        Nivel = 3'b000; tick(4);
        checks++; if (Fill !== 2'd0) begin errors++; $display("FAIL deb_glitch_fill: got %0d expected 0", Fill); end
        checks++; if (Alarme !== 1'b1) begin errors++; $display("FAIL deb_glitch_alarm: got %b expected 1", Alarme); end
        Nivel = 3'b001; tick(4);
        checks++; if (Fill !== 2'd0) begin errors++; $display("FAIL deb_accept_edge_fill: got %0d expected 0", Fill); end
        tick(1);
        checks++; if (Fill !== 2'd1) begin errors++; $display("FAIL deb_fill: got %0d expected 1", Fill); end
        checks++; if (Alarme !== 1'b0) begin errors++; $display("FAIL deb_alarm: got %b expected 0", Alarme); end
    endtask

    task automatic test_error_latch();
        Nivel = 3'b010; tick(5);
        checks++; if (ErroMedida !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", ErroMedida); end
        checks++; if (VEntrada !== 1'b0) begin errors++; $display("FAIL err_vent: got %b expected 0", VEntrada); end
        checks++; if (Alarme !== 1'b1) begin errors++; $display("FAIL err_alarm: got %b expected 1", Alarme); end
        checks++; if (Fill !== 2'd1) begin errors++; $display("FAIL err_fill_held: got %0d expected 1", Fill); end
        Nivel = 3'b011; tick(4);
        tick(7);
        checks++; if (ErroMedida !== 1'b1) begin errors++; $display("FAIL err_clr_early: got %b expected 1", ErroMedida); end
        checks++; if (Fill !== 2'd2) begin errors++; $display("FAIL err_clr_fill: got %0d expected 2", Fill); end
        tick(1);
        checks++; if (ErroMedida !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", ErroMedida); end
    endtask

    task automatic test_hysteresis();
        Nivel = 3'b001; tick(5);
        checks++; if (Fill !== 2'd1 || VEntrada !== 1'b1) begin errors++; $display("FAIL hys_f1: got Fill=%0d V=%b expected 1/1", Fill, VEntrada); end
        Nivel = 3'b011; tick(5);
        checks++; if (Fill !== 2'd2 || VEntrada !== 1'b1) begin errors++; $display("FAIL hys_f2_up: got Fill=%0d V=%b expected 2/1", Fill, VEntrada); end
        Nivel = 3'b111; tick(5);
        checks++; if (Fill !== 2'd3 || VEntrada !== 1'b0) begin errors++; $display("FAIL hys_f3: got Fill=%0d V=%b expected 3/0", Fill, VEntrada); end
        Nivel = 3'b011; tick(5);
        checks++; if (Fill !== 2'd2 || VEntrada !== 1'b0) begin errors++; $display("FAIL hys_f2_down: got Fill=%0d V=%b expected 2/0", Fill, VEntrada); end
        Nivel = 3'b001; tick(5);
        checks++; if (Fill !== 2'd1 || VEntrada !== 1'b1) begin errors++; $display("FAIL hys_reopen: got Fill=%0d V=%b expected 1/1", Fill, VEntrada); end
    endtask

    task automatic test_duty_limit();
        bit seen;
        Nivel = 3'b111; Usolo = 1; Uar = 1; Temp = 0;
        tick(5);
        for (int i = 0; i < 16; i++) begin
            checks++; if (Aspersor !== 1'b1 || Gotejamento !== 1'b0) begin
                errors++; $display("FAIL duty_run[%0d]: got A=%b G=%b expected 1/0", i, Aspersor, Gotejamento); end
            tick(1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (Aspersor !== 1'b0 || Gotejamento !== 1'b0) begin
                errors++; $display("FAIL duty_rest[%0d]: got A=%b G=%b expected 0/0", i, Aspersor, Gotejamento); end
            tick(1);
        end
        seen = 0;
        for (int i = 0; i < 3 && !seen; i++) begin
            if (Aspersor === 1'b1) seen = 1; else tick(1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL duty_restart: got A=%b expected new run within 3 cycles", Aspersor); end
    endtask

    task automatic test_method_latch();
        reset = 1'b1; tick(1); reset = 1'b0;
        Nivel = 3'b111; Usolo = 1; Uar = 1; Temp = 1;
        tick(5);
        checks++; if (Gotejamento !== 1'b1 || Aspersor !== 1'b0) begin errors++; $display("FAIL meth_start: got A=%b G=%b expected 0/1", Aspersor, Gotejamento); end
        Uar = 0; tick(6);
        checks++; if (Gotejamento !== 1'b1 || Aspersor !== 1'b0) begin errors++; $display("FAIL meth_uar0: got A=%b G=%b expected 0/1", Aspersor, Gotejamento); end
        Uar = 1; tick(6);
        checks++; if (Gotejamento !== 1'b1 || Aspersor !== 1'b0) begin errors++; $display("FAIL meth_uar1: got A=%b G=%b expected 0/1", Aspersor, Gotejamento); end
    endtask

    task automatic test_abort_reset();
        reset = 1'b1; tick(1); reset = 1'b0;
        Nivel = 3'b111; Usolo = 1; Uar = 1; Temp = 0;
        tick(5);
        checks++; if (Aspersor !== 1'b1) begin errors++; $display("FAIL abort_start: got A=%b expected 1", Aspersor); end
        tick(2);
        Nivel = 3'b101; tick(4);
        checks++; if (Aspersor !== 1'b1 || ErroMedida !== 1'b0) begin errors++; $display("FAIL abort_pre: got A=%b E=%b expected 1/0", Aspersor, ErroMedida); end
        tick(1);
        checks++; if (ErroMedida !== 1'b1 || Aspersor !== 1'b0 || Gotejamento !== 1'b0) begin
            errors++; $display("FAIL abort_edge: got E=%b A=%b G=%b expected 1/0/0", ErroMedida, Aspersor, Gotejamento); end
        checks++; if (VEntrada !== 1'b0 || Alarme !== 1'b1 || Fill !== 2'd3) begin
            errors++; $display("FAIL abort_side: got V=%b Al=%b Fill=%0d expected 0/1/3", VEntrada, Alarme, Fill); end
        tick(3);
        reset = 1'b1; tick(1);
        checks++; if ({Fill, ErroMedida, Aspersor, Gotejamento, VEntrada, Alarme} !== 7'b0) begin
            errors++; $display("FAIL abort_reset: got %b expected 0000000", {Fill, ErroMedida, Aspersor, Gotejamento, VEntrada, Alarme}); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_error_latch();
        test_hysteresis();
        test_duty_limit();
        test_method_latch();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
